resp_hex_formatter: RTL
=======================

Name: resp_hex_formatter

Overview:
- Sits directly downstream of the phase-bus command state machines.
- Consumes the response buffer they produce (up to 8 bytes, byte count, pending flag).
- Renders the buffer as an ASCII hex line, e.g. "AA,BB,CC,DD\r\n", and streams it byte-by-byte to the UART transmitter over a valid/ready handshake.
- Frees the state machines from any string formatting.

Parameters:
- MAX_BYTES, 8, depth of the response buffer; larger counts are clamped to this.
- SEP_CHAR, 8'h2C, separator between hex pairs (',').
- LOWERCASE, 0, 1 selects a–f digits, 0 selects A–F.

Ports:
- clock  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- resp_pending  in  1  level; a response is waiting in resp_bytes/resp_byte_count.
- resp_bytes  in  8 x MAX_BYTES  response bytes; index 0 is sent first.
- resp_byte_count  in  4  number of valid bytes, 0..15.
- resp_ack  out  1  one-cycle pulse; buffer captured, upstream must drop resp_pending.
- tx_data  out  8  ASCII character to the UART transmitter.
- tx_valid  out  1  tx_data is valid.
- tx_ready  in  1  UART transmitter accepts tx_data this cycle.
- busy  out  1  high from capture until the last character (LF) is accepted.

Behaviour:
- Reset: clock and reset are single-clock, asynchronous active-high. During reset, resp_ack=0, tx_valid=0, tx_data=8'h00, busy=0, state=IDLE, internal buffer and counters=0. Reset mid-line abandons the line immediately; no partial resume.
- Transfer rule: a character moves only when tx_valid && tx_ready on a rising edge. While tx_valid=1 and tx_ready=0, tx_data is held stable. tx_valid never drops without a transfer except on reset.
- Capture:
  - In IDLE with resp_pending=1 at edge N, latch all resp_bytes and eff_count = min(resp_byte_count, MAX_BYTES).
  - Same edge: resp_ack=1 for exactly one cycle, busy=1.
  - First character is presented with tx_valid=1 in cycle N+1.
- resp_pending is ignored while busy. If still high on return to IDLE, a new capture occurs; a pending that survives its ack is treated as a new response.
- States:
  - IDLE: wait for resp_pending.
  - HI: high nibble of byte[idx].
  - LO: low nibble of byte[idx].
  - SEP: SEP_CHAR.
  - CR: 8'h0D.
  - LF: 8'h0A.
  - CK_STAR, CK_HI, CK_LO: present only with the optional feature.
- Transitions (each advances on transfer):
  - IDLE→HI if eff_count>0, else IDLE→CR.
  - HI→LO.
  - LO→SEP if idx<eff_count-1, else LO→CR (or CK_STAR with the feature).
  - SEP→HI with idx+1.
  - CR→LF.
  - LF→IDLE, clearing busy in the same cycle.
- Nibble mapping: 0–9 → 8'h30+n; 10–15 → 8'h41+(n-10), or 8'h61+(n-10) when LOWERCASE=1.
- Line length: 3*eff_count+1 characters for eff_count>0; 2 characters for eff_count=0.
- Throughput: one character per cycle when tx_ready is held high, with no bubbles between states.
- idx is 3 bits wide for MAX_BYTES=8 and never wraps past eff_count-1.

Optional Feature:
- Macro: RESP_HEX_CHECKSUM_EN.
- Defined:
  - XOR of the eff_count captured bytes is computed at capture (8'h00 if eff_count=0).
  - After the last LO (or directly from IDLE when eff_count=0), emit '*' then two hex characters, then CR LF.
  - Line length grows by 3.
- Undefined: CK_* states and checksum register are absent; line ends directly with CR LF.

Decomposition:
- Package resp_fmt_pkg holds:
  - state enum resp_fmt_state_t;
  - ASCII constants ASCII_CR, ASCII_LF, ASCII_COMMA, ASCII_STAR;
  - function nibble_to_ascii(nibble, lowercase).
- No sub-module; a single flat FSM with one data path is natural.

Test Plan:
- Bytes AA,BB,CC,DD; count=4; tx_ready=1 → resp_ack one cycle. Thirteen consecutive characters "AA,BB,CC,DD\r\n", first one cycle after capture. busy falls with LF.
- Count=0 → "\r\n" only, resp_ack pulsed, busy high for exactly 2 transfers.
- Count=12, bytes 00..07 → clamped to 8: "00,01,02,03,04,05,06,07\r\n" (25 chars).
- Bytes 3C,0F; tx_ready toggling 1-0-0-1 → tx_data stable while stalled. Output "3C,0F\r\n", no duplicated or dropped characters. resp_pending re-raised mid-line is not acked until after LF.
- Reset asserted after 5 characters of a 4-byte line → tx_valid=0 and busy=0 immediately (asynchronous). After release with resp_pending=1, the full line restarts from the first character.
- With RESP_HEX_CHECKSUM_EN: bytes 01,02,04 → "01,02,04*07\r\n". With LOWERCASE=1 and byte AB → "ab*ab\r\n".

Source files
------------

// File: rtl/resp_fmt_pkg.sv
// resp_fmt_pkg: shared types and helpers for the response hex formatter.
//   resp_fmt_state_t  - formatter FSM states (checksum states exist only when
//                       RESP_HEX_CHECKSUM_EN is defined)
//   ASCII_*           - fixed characters used in the rendered line
//   nibble_to_ascii() - one hex digit to its ASCII code
package resp_fmt_pkg;

  typedef enum logic [3:0] {
    StIdle,
    StHi,
    StLo,
    StSep,
    StCr,
    StLf
`ifdef RESP_HEX_CHECKSUM_EN
    ,
    StCkStar,
    StCkHi,
    StCkLo
`endif
  } resp_fmt_state_t;

  localparam logic [7:0] ASCII_CR    = 8'h0D;
  localparam logic [7:0] ASCII_LF    = 8'h0A;
  localparam logic [7:0] ASCII_COMMA = 8'h2C;
  localparam logic [7:0] ASCII_STAR  = 8'h2A;

  function automatic logic [7:0] nibble_to_ascii(input logic [3:0] nibble,
                                                 input logic       lowercase);
    if (nibble < 4'd10) begin
      return 8'h30 + 8'(nibble);
    end
    return (lowercase ? 8'h61 : 8'h41) + 8'(nibble) - 8'd10;
  endfunction

endpackage

// File: rtl/resp_hex_formatter_if.sv
// resp_hex_formatter_if: response-buffer handshake plus UART character stream.
//   resp_pending/resp_bytes/resp_byte_count/resp_ack - buffer from the command FSMs
//   tx_data/tx_valid/tx_ready                          - character stream to the UART
//   busy                                               - a line is in progress
// modport master: the formatter side; modport slave: its environment.
interface resp_hex_formatter_if #(
  parameter int unsigned MAX_BYTES = 8
) ();
  logic                      resp_pending;
  logic [MAX_BYTES-1:0][7:0] resp_bytes;
  logic [3:0]                resp_byte_count;
  logic                      resp_ack;
  logic [7:0]                tx_data;
  logic                      tx_valid;
  logic                      tx_ready;
  logic                      busy;

  modport master (
    input  resp_pending, resp_bytes, resp_byte_count, tx_ready,
    output resp_ack, tx_data, tx_valid, busy
  );

  modport slave (
    output resp_pending, resp_bytes, resp_byte_count, tx_ready,
    input  resp_ack, tx_data, tx_valid, busy
  );
endinterface

// File: rtl/resp_hex_formatter.sv
// resp_hex_formatter: renders a captured response buffer as an ASCII hex line
// ("AA,BB,CC\r\n") and streams it one character per transfer.
//   clock, reset : system clock, asynchronous active-high reset
//   bus (master) : response buffer in / resp_ack out, tx_data/tx_valid/tx_ready out,
//                  busy out
// Optional: define RESP_HEX_CHECKSUM_EN to append "*XX" (XOR of the bytes) before CR LF.
module resp_hex_formatter
  import resp_fmt_pkg::*;
#(
  parameter int unsigned MAX_BYTES = 8,
  parameter logic [7:0]  SEP_CHAR  = ASCII_COMMA,
  parameter logic        LOWERCASE = 1'b0
) (
  input  logic                 clock,
  input  logic                 reset,
  resp_hex_formatter_if.master bus
);

  localparam int unsigned IdxW   = (MAX_BYTES > 1) ? $clog2(MAX_BYTES) : 1;
  localparam logic [3:0]  MaxCnt = 4'(MAX_BYTES);

`ifdef RESP_HEX_CHECKSUM_EN
  localparam resp_fmt_state_t TailState = StCkStar;
`else
  localparam resp_fmt_state_t TailState = StCr;
`endif

  resp_fmt_state_t           state_q, nxt_state;
  logic [IdxW-1:0]           idx_q, nxt_idx;
  logic [3:0]                cnt_q, cap_cnt;
  logic [MAX_BYTES-1:0][7:0] buf_q;
  logic                      ack_q, valid_q, busy_q;
  logic [7:0]                data_q, nxt_char, cur_byte;
  logic                      capture, transfer, advance, last_byte;
`ifdef RESP_HEX_CHECKSUM_EN
  logic [7:0]                ck_q, cap_ck, nxt_ck;
`endif

  assign bus.resp_ack = ack_q;
  assign bus.tx_data  = data_q;
  assign bus.tx_valid = valid_q;
  assign bus.busy     = busy_q;

  always_comb begin
    cap_cnt   = (bus.resp_byte_count > MaxCnt) ? MaxCnt : bus.resp_byte_count;
    capture   = (state_q == StIdle) && bus.resp_pending;
    transfer  = valid_q && bus.tx_ready;
    advance   = capture || transfer;
    last_byte = (4'(idx_q) == (cnt_q - 4'd1));
`ifdef RESP_HEX_CHECKSUM_EN
    cap_ck = 8'h00;
    for (int unsigned i = 0; i < MAX_BYTES; i++) begin
      if (i < 32'(cap_cnt)) cap_ck = cap_ck ^ bus.resp_bytes[IdxW'(i)];
    end
`endif

    nxt_state = state_q;
    nxt_idx   = idx_q;
    unique case (state_q)
      StIdle: begin
        nxt_state = (cap_cnt != 4'd0) ? StHi : TailState;
        nxt_idx   = '0;
      end
      StHi:  nxt_state = StLo;
      StLo:  nxt_state = last_byte ? TailState : StSep;
      StSep: begin
        nxt_state = StHi;
        nxt_idx   = idx_q + 1'b1;
      end
      StCr:  nxt_state = StLf;
      StLf:  nxt_state = StIdle;
`ifdef RESP_HEX_CHECKSUM_EN
      StCkStar: nxt_state = StCkHi;
      StCkHi:   nxt_state = StCkLo;
      StCkLo:   nxt_state = StCr;
`endif
      default: nxt_state = StIdle;
    endcase

    // The character is rendered for the state being entered, so it is ready the
    // cycle that state begins; on capture the buffer register is not loaded yet.
    cur_byte = capture ? bus.resp_bytes[0] : buf_q[nxt_idx];
`ifdef RESP_HEX_CHECKSUM_EN
    nxt_ck = capture ? cap_ck : ck_q;
`endif
    case (nxt_state)
      StHi:  nxt_char = nibble_to_ascii(cur_byte[7:4], LOWERCASE);
      StLo:  nxt_char = nibble_to_ascii(cur_byte[3:0], LOWERCASE);
      StSep: nxt_char = SEP_CHAR;
      StCr:  nxt_char = ASCII_CR;
      StLf:  nxt_char = ASCII_LF;
`ifdef RESP_HEX_CHECKSUM_EN
      StCkStar: nxt_char = ASCII_STAR;
      StCkHi:   nxt_char = nibble_to_ascii(nxt_ck[7:4], LOWERCASE);
      StCkLo:   nxt_char = nibble_to_ascii(nxt_ck[3:0], LOWERCASE);
`endif
      default: nxt_char = 8'h00;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      idx_q   <= '0;
      cnt_q   <= '0;
      buf_q   <= '0;
      ack_q   <= 1'b0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      data_q  <= 8'h00;
`ifdef RESP_HEX_CHECKSUM_EN
      ck_q    <= 8'h00;
`endif
    end else begin
      ack_q <= capture;
      if (advance) begin
        state_q <= nxt_state;
        idx_q   <= nxt_idx;
        data_q  <= nxt_char;
        valid_q <= (nxt_state != StIdle);
        busy_q  <= (nxt_state != StIdle);
      end
      if (capture) begin
        buf_q <= bus.resp_bytes;
        cnt_q <= cap_cnt;
`ifdef RESP_HEX_CHECKSUM_EN
        ck_q  <= cap_ck;
`endif
      end
    end
  end

endmodule
